// File: rtl/register_file_dump_reader.sv
// Sequential register-file dump reader: walks an address range through one read port and
// streams each word with its address. Optional running checksum output: DUMP_CHECKSUM_EN.
module register_file_dump_reader #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_synchronous,
    input  logic         start,
    input  logic [3:0]   inp_first_address,
    input  logic [3:0]   inp_last_address,
    output logic [3:0]   out_read_address,
    input  logic [W-1:0] inp_read_data,
    output logic [W-1:0] out_data,
    output logic [3:0]   out_address,
    output logic         out_valid,
    input  logic         inp_ready,
    output logic         out_busy,
    output logic         out_done
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [W-1:0] out_checksum
`endif
);

    typedef enum logic [1:0] {StIdle, StCapture, StPresent, StDone} state_e;

    state_e     state_q;
    logic [3:0] cur_q;
    logic [3:0] last_q;

    // The read port follows the walk pointer; data is sampled on the CAPTURE edge.
    assign out_read_address = cur_q;

    always_ff @(posedge clk) begin
        if (reset_synchronous) begin
            state_q     <= StIdle;
            cur_q       <= 4'd0;
            last_q      <= 4'd0;
            out_data    <= '0;
            out_address <= 4'd0;
            out_valid   <= 1'b0;
            out_busy    <= 1'b0;
            out_done    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            out_checksum <= '0;
`endif
        end else begin
            out_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cur_q    <= inp_first_address;
                        last_q   <= inp_last_address;
                        out_busy <= 1'b1;
                        state_q  <= StCapture;
`ifdef DUMP_CHECKSUM_EN
                        out_checksum <= '0;
`endif
                    end
                end
                StCapture: begin
                    out_data    <= inp_read_data;
                    out_address <= cur_q;
                    out_valid   <= 1'b1;
                    state_q     <= StPresent;
                end
                StPresent: begin
                    if (inp_ready) begin
                        out_valid <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        out_checksum <= out_checksum + out_data;
`endif
                        if (cur_q == last_q) begin
                            out_busy <= 1'b0;
                            out_done <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            // 4-bit increment wraps 15 -> 0 for ranges with last < first.
                            cur_q   <= cur_q + 4'd1;
                            state_q <= StCapture;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/register_file_dump_reader.md
Name: register_file_dump_reader

Overview:
Sequential reader for the 16-entry register file. On a start pulse it walks an address range through one register-file read port. Each word it reads is presented on a valid/ready output stream, tagged with its address, for debug dump, context save or a scan-out link. It sits beside the register file and owns one read-address input of that file while busy.

Parameters:
W, 16, data width; must equal the register file data width.

Ports:
clk  input  1  rising-edge clock
reset_synchronous  input  1  synchronous active-high reset
start  input  1  request a dump; sampled only in IDLE
inp_first_address  input  4  first register of the range; latched on start
inp_last_address  input  4  last register of the range; latched on start
out_read_address  output  4  drives the register-file read address port
inp_read_data  input  W  register-file read data for out_read_address (combinational, same cycle)
out_data  output  W  captured register word
out_address  output  4  register index of out_data
out_valid  output  1  out_data and out_address are valid
inp_ready  input  1  consumer accepts the word when out_valid and inp_ready are both 1
out_busy  output  1  dump in progress (CAPTURE or PRESENT)
out_done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Clocking: single clock clk. Reset is synchronous, active-high, via reset_synchronous. Every state element resets on the clk edge where reset_synchronous=1.
- Reset values:
  - state=IDLE
  - out_read_address=0, out_address=0, out_data=0
  - out_valid=0, out_busy=0, out_done=0
- Reset has priority over all other inputs. Reset mid-dump aborts with no done pulse, and no partial word remains valid.
- Internal registers: cur (4-bit current address), last (4-bit), state.
- out_read_address = cur in every state.
- State IDLE:
  - start=1 -> cur<=inp_first_address, last<=inp_last_address, go to CAPTURE.
  - start=0 -> stay in IDLE.
- State CAPTURE (out_busy=1, out_valid=0):
  - on the edge, out_data<=inp_read_data, out_address<=cur, out_valid<=1, go to PRESENT.
- State PRESENT (out_busy=1, out_valid=1):
  - out_data and out_address are held stable while inp_ready=0.
  - On handshake with cur==last: out_valid<=0, go to DONE.
  - On handshake otherwise: out_valid<=0, cur<=cur+1 mod 16, go to CAPTURE.
- State DONE (out_busy=0, out_done=1 for exactly this cycle) -> IDLE.
- Timing:
  - Latency is 2 cycles from start high in IDLE to the first out_valid=1.
  - Peak throughput is one word per 2 cycles.
- Range and wrap:
  - Word count is ((last-first) mod 16)+1, from 1 to 16.
  - last<first wraps 15->0.
  - first==last gives 1 word.
  - first=last+1 gives all 16 registers.
- Snapshot: each word is the register value at its CAPTURE edge. Register-file writes after capture do not change a presented word.
- start is ignored in CAPTURE, PRESENT and DONE; there is no queuing.
- inp_first_address and inp_last_address changing after start have no effect.
- Asserting inp_ready while out_valid=0 has no effect.

Optional Feature:
Macro DUMP_CHECKSUM_EN.
- Defined: adds output port out_checksum (W bits).
  - Holds the running sum mod 2^W of all words accepted in the current dump.
  - Updated on each handshake and cleared to 0 when start is accepted in IDLE.
  - Holds its value through DONE and IDLE until the next start.
  - Reset value is 0.
- Undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
1. Register file R[i]=16'h1000+i, reset, start with first=0 last=3, inp_ready=1 -> out_valid on alternate cycles carrying (0,1000),(1,1001),(2,1002),(3,1003); out_done one cycle after the 4th handshake; out_busy=0 afterwards.
2. inp_ready=0 for 3 cycles while presenting address 2 -> out_valid stays 1 and out_data=1002, out_address=2 stay stable; the word is accepted on the cycle ready returns to 1 and the sequence resumes at address 3.
3. Wrap: first=14, last=1 -> addresses 14,15,0,1 in order, then done. Full range first=5, last=4 -> 16 words, the last one address 4.
4. Single word first=last=7 -> exactly one word (7,1007), then done. start pulsed while busy in scenario 1 -> ignored: no extra words and word count unchanged.
5. Snapshot and reset:
   - Write R3=BEEF after address 3 is captured but before its handshake -> the presented word stays 1003.
   - Assert reset_synchronous after 2 words -> next cycle out_valid, out_busy and out_done are 0; a new start then dumps cleanly from its new first address.
6. With DUMP_CHECKSUM_EN defined, R0=FFFF, R1=0002, range 0..1 -> out_checksum=0001 at out_done. A following start clears out_checksum to 0.
